// File: rtl/sseg_scan_mux_if.sv
// Bus between the display scanner and its producer/consumer: value loading,
// live display controls and the decoder/anode drive back out.
interface sseg_scan_mux_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [DIGITS-1:0]   digit_en;
    logic                lzb;
    logic [3:0]          num;
    logic [DIGITS-1:0]   anode;
    logic                blank;
    logic                frame_tick;

    // Producer side: supplies value/controls, observes the scan outputs.
    modport master (
        output value, load, digit_en, lzb,
        input  num, anode, blank, frame_tick
    );

    // Scanner side.
    modport slave (
        input  value, load, digit_en, lzb,
        output num, anode, blank, frame_tick
    );
endinterface

// File: rtl/sseg_scan_mux.sv
// Multiplexed seven-segment scanner. Time-slices a double-buffered hex value
// one digit per slot, with an anti-ghost blank gap at the start of each slot,
// per-digit enables and optional leading-zero blanking. New values are only
// committed at the frame boundary so a frame never mixes old and new digits.
module sseg_scan_mux #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    sseg_scan_mux_if.slave bus
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef logic [DIGITS-1:0][3:0] nibbles_t;

    // Scan position
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // Double buffer: pending takes loads, shadow is what is displayed
    nibbles_t          pending_q, pending_d;
    nibbles_t          shadow_q, shadow_d;

    // Registered outputs
    logic [3:0]        num_q, num_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic              blank_q, blank_d;
    logic              frame_tick_q, frame_tick_d;

    logic              slot_end;
    logic              wrap;
    logic [DIGITS-1:0] upper_zero;
    logic              zero_run;
    logic              zero_blanked;
    logic              lit;

    // Flag, per digit, whether it and every more significant digit is zero.
    always_comb begin
        upper_zero = '0;
        zero_run   = 1'b1;
        // NOTE: zero_run is a combinational accumulator inside one evaluation,
        // so it uses blocking assignments and is seeded before the loop; a
        // variable read before being written here would infer a latch.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run & (shadow_q[i] == 4'h0);
            upper_zero[i] = zero_run;
        end
    end

    // Next scan position, buffer updates and the output image of this slot.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        shadow_d     = shadow_q;
        frame_tick_d = 1'b0;
        anode_d      = '1;

        slot_end = (cnt_q == CNT_W'(PRESCALE - 1));
        wrap     = slot_end && (idx_q == IDX_W'(DIGITS - 1));

        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (bus.load) begin
            pending_d = bus.value;
        end

        // A load on the wrap edge itself goes straight to the display.
        if (wrap) begin
            shadow_d     = bus.load ? nibbles_t'(bus.value) : pending_q;
            frame_tick_d = 1'b1;
        end

        // Outputs reflect the pre-edge slot; digit 0 is never zero-blanked.
        zero_blanked = bus.lzb && (idx_q != '0) && upper_zero[idx_q];
        lit          = (cnt_q >= CNT_W'(BLANK_CYCLES)) && bus.digit_en[idx_q]
                       && !zero_blanked;

        num_d = shadow_q[idx_q];
        if (lit) begin
            anode_d[idx_q] = 1'b0;
        end
        blank_d = !lit;
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every flop here, including the digit buffers, is reset so the
        // display starts dark and deterministic; sequential state uses <= only.
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            shadow_q     <= '0;
            num_q        <= 4'h0;
            anode_q      <= '1;
            blank_q      <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            num_q        <= num_d;
            anode_q      <= anode_d;
            blank_q      <= blank_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.num        = num_q;
    assign bus.anode      = anode_q;
    assign bus.blank      = blank_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_sseg_scan_mux.sv
// Bench for sseg_scan_mux: directed scenarios plus random traffic, every
// registered output compared each cycle against a frame-arithmetic model.
module tb_sseg_scan_mux;
    localparam int DIGITS   = 4;
    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;
    localparam int FRAME    = DIGITS * PRESCALE;

    logic clk;
    logic rst_n;

    sseg_scan_mux_if #(.DIGITS(DIGITS)) bus ();

    sseg_scan_mux #(
        .DIGITS      (DIGITS),
        .PRESCALE    (PRESCALE),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_bad;

    // Model: k = clock edges since reset release minus one (the pre-edge cycle).
    int          k;
    logic [15:0] shown;
    logic [15:0] pending;
    int          ticks_seen;
    int          ticks_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (k=%0d, t=%0t)", tag, got, exp, k, $time);
        end
    endtask

    task automatic model_reset();
        k       = 0;
        shown   = '0;
        pending = '0;
    endtask

    // One clock: predict, clock, compare, then return on the falling edge.
    task automatic tick();
        int          cnt;
        int          idx;
        bit          lit;
        bit          wrap;
        logic [3:0]  exp_num;
        logic [3:0]  exp_anode;
        cnt     = k % PRESCALE;
        idx     = (k / PRESCALE) % DIGITS;
        exp_num = shown[4*idx +: 4];
        lit     = (cnt >= BLANK) && bus.digit_en[idx]
                  && !(bus.lzb && idx >= 1 && (shown >> (4*idx)) == 16'h0);
        exp_anode = lit ? ~(4'b0001 << idx) : 4'hF;
        wrap    = (k % FRAME) == FRAME - 1;
        if (wrap) shown = bus.load ? bus.value : pending;
        if (bus.load) pending = bus.value;
        if (wrap) ticks_exp++;
        @(posedge clk);
        #1;
        if (bus.frame_tick) ticks_seen++;
        check("num", 32'(bus.num), 32'(exp_num));
        check("anode", 32'(bus.anode), 32'(exp_anode));
        check("blank", 32'(bus.blank), 32'(!lit));
        check("frame_tick", 32'(bus.frame_tick), 32'(wrap));
        k++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the next edge to be taken is pre-edge cycle `pos` of a frame.
    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) tick();
    endtask

    task automatic load_once(input logic [15:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        bus.value = $urandom;
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        ticks_seen = 0;
        ticks_exp  = 0;
        bus.value    = '0;
        bus.load     = 1'b0;
        bus.digit_en = 4'hF;
        bus.lzb      = 1'b0;
        rst_n        = 1'b0;
        model_reset();
        #12;
        check("rst_num", 32'(bus.num), 32'h0);
        check("rst_anode", 32'(bus.anode), 32'hF);
        check("rst_blank", 32'(bus.blank), 32'h1);
        check("rst_frame_tick", 32'(bus.frame_tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scan of zeros, all digits enabled.
        run(40);

        // Load during the digit-1 slot: commits only at the next wrap.
        run_to(10);
        load_once(16'h1234);
        run(FRAME + 20);

        // Leading-zero blanking of a committed 0x0050.
        bus.lzb = 1'b1;
        load_once(16'h0050);
        run(2 * FRAME);
        bus.lzb = 1'b0;

        // Load on the wrap edge goes straight to the next frame.
        run_to(FRAME - 1);
        load_once(16'hABCD);
        check("wrap_load_shown", 32'(shown), 32'hABCD);
        run(FRAME + 4);

        // Sparse digit enables.
        bus.digit_en = 4'b0101;
        run(FRAME + 8);
        bus.digit_en = 4'hF;

        // Mid-slot asynchronous reset pulse between edges.
        run_to(13);
        #2 rst_n = 1'b0;
        #1;
        check("pulse_num", 32'(bus.num), 32'h0);
        check("pulse_anode", 32'(bus.anode), 32'hF);
        check("pulse_blank", 32'(bus.blank), 32'h1);
        #1 rst_n = 1'b1;
        model_reset();
        run(FRAME + 10);

        // Random traffic: sparse loads with variable leading zeros, live controls.
        for (int i = 0; i < 800; i++) begin
            logic [15:0] v;
            if ($urandom_range(0, 15) == 0) bus.digit_en = 4'($urandom);
            if ($urandom_range(0, 31) == 0) bus.lzb = 1'($urandom);
            v = 16'($urandom) >> (4 * $urandom_range(0, 4));
            bus.value = v;
            bus.load  = ($urandom_range(0, 9) == 0);
            if ((k % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1) bus.load = 1'b1;
            tick();
        end
        bus.load = 1'b0;

        check("frame_tick_count", 32'(ticks_seen), 32'(ticks_exp));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
